mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mips_pkg.sv | 21 ++
 rtl/arb_starve_cnt.sv | 39 +++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared arbiter state encoding and starvation-limit default.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DRAIN  = 2'd3
    } arb_state_t;

    localparam int STARVE_MAX_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/arb_starve_cnt.sv
// ============================================================================
// Module      : arb_starve_cnt
// Description : Saturating count of data-port wins taken while fetch waits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_starve_cnt
    import mips_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int                 c_cnt_w = $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(STARVE_MAX);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign sat = (r_count == c_max);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Fetch/data arbiter onto one single-port memory, with
//               starvation guard for fetch and flush-drain of stale fetches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        flush,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    arb_state_t r_state;

    logic w_if_elig;
    logic w_d_elig;
    logic w_sat;
    logic w_grant_i;
    logic w_grant_d;

    // A port whose ready pulse is high this cycle is still holding its old
    // request, so it must not be granted again.
    assign w_if_elig = if_req & ~if_ready;
    assign w_d_elig  = d_req  & ~d_ready;
    assign w_grant_i = (r_state == ST_IDLE) && w_if_elig && (!w_d_elig || w_sat);
    assign w_grant_d = (r_state == ST_IDLE) && w_d_elig && !w_grant_i;

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (w_grant_d & w_if_elig),
        .clr (w_grant_i),
        .sat (w_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            if_rdata  <= '0;
            if_ready  <= 1'b0;
            d_rdata   <= '0;
            d_ready   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_byte  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_i) begin
                        r_state   <= ST_BUSY_I;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_byte  <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end else if (w_grant_d) begin
                        r_state   <= ST_BUSY_D;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_byte  <= d_byte;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end
                end
                ST_BUSY_I: begin
                    // A flush coinciding with the ack simply discards the word.
                    if (flush) begin
                        if (mem_ack) begin
                            r_state <= ST_IDLE;
                            mem_en  <= 1'b0;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (mem_ack) begin
                        r_state  <= ST_IDLE;
                        mem_en   <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_ready <= 1'b1;
                    end
                end
                ST_BUSY_D: begin
                    if (mem_ack) begin
                        r_state <= ST_IDLE;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        d_ready <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack) begin
                        r_state <= ST_IDLE;
                        mem_en  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
